instruction_fetch_unit: RTL
===========================

Name: instruction_fetch_unit

Overview:
Fetch stage directly upstream of JumpControlBlock. It owns the 8-bit program counter and drives the instruction ROM address. It registers the fetched word into the fetch/decode register, producing `ins` and `Current_Address` for JumpControlBlock. It consumes `jmp_loc`/`pc_mux_sel` to redirect the PC, flushes the wrong-path slot, and holds a redirect that arrives during a stall.

Parameters:
ADDR_W, 8, PC / instruction-address width
INS_W, 24, instruction word width
RESET_VEC, 8'h00, PC value after reset
NOP_WORD, 24'h000000, word inserted into `ins` on reset and flush

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset (0 at a rising edge resets the block)
jmp_loc  input  ADDR_W  redirect target from JumpControlBlock
pc_mux_sel  input  1  1 = take `jmp_loc` as next PC
stall  input  1  1 = freeze PC and fetch register (downstream hazard)
imem_addr  output  ADDR_W  instruction ROM address; combinationally equal to `pc`
imem_data  input  INS_W  ROM read data, asynchronous, valid in the same cycle as `imem_addr`
ins  output  INS_W  registered instruction to JumpControlBlock/decode
Current_Address  output  ADDR_W  registered address of the word in `ins`
ins_valid  output  1  1 = `ins` is a real fetched instruction; 0 = bubble

Behaviour:
- Internal state: `pc` (ADDR_W), `pend_addr` (ADDR_W), FSM `state` with states BOOT, RUN, HOLD_REDIR.
- Reset (reset==0 at posedge), overrides everything:
  - `pc`=RESET_VEC, `ins`=NOP_WORD, `Current_Address`=RESET_VEC, `ins_valid`=0, `pend_addr`=0, `state`=BOOT.
  - Asserting reset mid-operation discards any pending redirect.
- BOOT: lasts exactly one cycle and ignores `stall`.
  - If `pc_mux_sel`=1, `pc`<=`jmp_loc`; otherwise `pc` holds.
  - `ins`/`ins_valid` stay NOP/0. Next state is RUN.
- RUN, stall=0, pc_mux_sel=0:
  - `ins`<=`imem_data`, `Current_Address`<=`pc`, `ins_valid`<=1, `pc`<=`pc`+1.
  - Fetch-to-`ins` latency is 1 cycle.
- RUN, stall=0, pc_mux_sel=1 (flush):
  - `pc`<=`jmp_loc`, `ins`<=NOP_WORD, `ins_valid`<=0, `Current_Address` holds.
  - First target instruction appears in `ins` 2 cycles after `pc_mux_sel` is sampled.
- RUN, stall=1, pc_mux_sel=0: `pc`, `ins`, `Current_Address`, `ins_valid` all hold.
- RUN, stall=1, pc_mux_sel=1:
  - `pend_addr`<=`jmp_loc`, next state HOLD_REDIR.
  - All outputs hold; the redirect must not be lost.
- HOLD_REDIR, stall=1: outputs hold. If `pc_mux_sel`=1, `pend_addr`<=`jmp_loc` (latest redirect wins).
- HOLD_REDIR, stall=0:
  - `pc`<=(`pc_mux_sel` ? `jmp_loc` : `pend_addr`); a same-cycle redirect beats the pending one.
  - `ins`<=NOP_WORD, `ins_valid`<=0, `Current_Address` holds, next state RUN.
- PC arithmetic is modulo 2^ADDR_W: 8'hFF+1 wraps to 8'h00 with no flag.
- `jmp_loc`=`pc` is legal and re-fetches the same address.
- Outputs other than `imem_addr` are registered; there are no combinational paths from inputs to `ins`, `Current_Address` or `ins_valid`.
- Unused FSM encodings return to BOOT at the next clock.

Decomposition:
- Shared package holds: state encoding (BOOT=2'd0, RUN=2'd1, HOLD_REDIR=2'd2), ADDR_W/INS_W defaults, and NOP_WORD. JumpControlBlock uses the same widths and NOP definition.
- No sub-module: PC, redirect latch and fetch register stay in one module of about 150 lines.

Test Plan:
1. Reset=0 for 2 clocks, then 1 → `ins`=0, `ins_valid`=0, `Current_Address`=00 during BOOT; `imem_addr` sequence is 00,00,01,02; `ins` shows ROM[00] with `Current_Address`=00 on the 3rd clock after release.
2. PC=05 in RUN, pulse pc_mux_sel=1 with jmp_loc=8'h40 for 1 cycle → next cycle `ins_valid`=0, `ins`=NOP, `imem_addr`=40; the following cycle `ins`=ROM[40], `Current_Address`=40.
3. stall=1 and pc_mux_sel=1 (jmp_loc=8'h20) at PC=10, then stall held 3 cycles → `imem_addr` stays 10 and outputs frozen; on stall=0, `pc`=20 and `ins`=NOP; ROM[20] appears one cycle later.
4. In HOLD_REDIR with pending 8'h20, assert pc_mux_sel with jmp_loc=8'h30 in the same cycle stall drops → `pc`=30, not 20.
5. Run from PC=FE without stalls → `imem_addr` goes FE, FF, 00, 01; `Current_Address` trails by one cycle.
6. Assert reset=0 while in HOLD_REDIR → next cycle `pc`=00, state BOOT, pending redirect discarded (no jump to the old `pend_addr` after release).

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit_pkg
// Shared definitions for the fetch stage and its downstream consumer
// (JumpControlBlock): default address/instruction widths, the bubble word
// inserted on reset/flush, and the fetch FSM state encoding.
// -----------------------------------------------------------------------------
package instruction_fetch_unit_pkg;

  localparam int IFU_ADDR_W = 8;
  localparam int IFU_INS_W  = 24;

  // Bubble word placed into the fetch/decode register on reset and flush.
  localparam logic [IFU_INS_W-1:0] IFU_NOP_WORD = 24'h000000;

  // Fetch FSM encoding. The 2'd3 encoding is unused and recovers to BOOT.
  typedef enum logic [1:0] {
    BOOT       = 2'd0,
    RUN        = 2'd1,
    HOLD_REDIR = 2'd2
  } ifu_state_t;

endpackage

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
// Fetch stage directly upstream of JumpControlBlock. Owns the program counter,
// drives the asynchronous instruction ROM address, and registers the fetched
// word into the fetch/decode register. Redirects (pc_mux_sel/jmp_loc) flush the
// wrong-path slot; a redirect arriving while stalled is parked in pend_addr and
// applied when the stall releases.
//
// Ports:
//   clk             system clock, rising edge
//   reset           synchronous, active-low reset
//   jmp_loc         redirect target
//   pc_mux_sel      1 = next PC is jmp_loc
//   stall           1 = freeze PC and fetch register
//   imem_addr       ROM address, combinationally equal to the PC
//   imem_data       ROM read data, valid in the same cycle as imem_addr
//   ins             registered instruction
//   Current_Address registered address of the word in ins
//   ins_valid       1 = ins is a real fetched instruction, 0 = bubble
//   dbg_state       current fetch FSM state (observation only)
//
// Flow control: ins_valid qualifies ins/Current_Address every cycle. There is
// no ready; stall is the downstream back-pressure. While stall=1 the fetch
// register holds, so a valid word stays presented until stall drops.
// -----------------------------------------------------------------------------
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int                ADDR_W    = IFU_ADDR_W,
  parameter int                INS_W     = IFU_INS_W,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [INS_W-1:0]  NOP_WORD  = INS_W'(IFU_NOP_WORD)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] jmp_loc,
  input  logic              pc_mux_sel,
  input  logic              stall,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [INS_W-1:0]  imem_data,
  output logic [INS_W-1:0]  ins,
  output logic [ADDR_W-1:0] Current_Address,
  output logic              ins_valid,
  output ifu_state_t        dbg_state
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pend_addr;
  ifu_state_t        state;

  // The ROM is asynchronous, so the PC itself is the fetch address.
  assign imem_addr = pc;
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc              <= RESET_VEC;
      pend_addr       <= '0;
      ins             <= NOP_WORD;
      Current_Address <= RESET_VEC;
      ins_valid       <= 1'b0;
      state           <= BOOT;
    end else begin
      case (state)
        // Single settling cycle after reset; stall is ignored here so the
        // first fetch is never delayed by stale hazard state.
        BOOT: begin
          if (pc_mux_sel) begin
            pc <= jmp_loc;
          end
          state <= RUN;
        end

        RUN: begin
          if (!stall) begin
            if (pc_mux_sel) begin
              // Flush: the word at the current PC is on the wrong path.
              pc        <= jmp_loc;
              ins       <= NOP_WORD;
              ins_valid <= 1'b0;
            end else begin
              ins             <= imem_data;
              Current_Address <= pc;
              ins_valid       <= 1'b1;
              pc              <= pc + ADDR_W'(1);
            end
          end else if (pc_mux_sel) begin
            // Redirect during a stall: park it rather than drop it.
            pend_addr <= jmp_loc;
            state     <= HOLD_REDIR;
          end
        end

        HOLD_REDIR: begin
          if (stall) begin
            if (pc_mux_sel) begin
              pend_addr <= jmp_loc;  // latest redirect wins
            end
          end else begin
            // A redirect presented in the release cycle is newer than the
            // parked one, so it takes priority.
            pc        <= pc_mux_sel ? jmp_loc : pend_addr;
            ins       <= NOP_WORD;
            ins_valid <= 1'b0;
            state     <= RUN;
          end
        end

        default: begin
          state <= BOOT;
        end
      endcase
    end
  end

endmodule
